// File: rtl/cpu_ad48_pkg.sv
// Shared definitions for the cpu_ad48 core: field constants and instruction encoders
// used by the RTL and by benches that assemble programs into IMEM.
package cpu_ad48_pkg;

    localparam int DATA_W = 48;

    localparam logic [3:0] OP_SYS    = 4'd0;
    localparam logic [3:0] OP_ALUI_A = 4'd1;
    localparam logic [3:0] OP_ALUI_D = 4'd2;
    localparam logic [3:0] OP_LD     = 4'd3;
    localparam logic [3:0] OP_ST     = 4'd4;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4;
    localparam logic [3:0] F_SHL = 4'd5;
    localparam logic [3:0] F_SHR = 4'd6;
    localparam logic [3:0] F_SAR = 4'd7;
    localparam logic [3:0] F_MOV = 4'd8;

    localparam logic [3:0] SYS_HALT = 4'hF;

    function automatic logic [DATA_W-1:0] to48(input int v);
        return 48'(v);
    endfunction

    function automatic logic [32:0] pack_disp33(input int d);
        logic [DATA_W-1:0] t;
        t = to48(d);
        return t[32:0];
    endfunction

    function automatic logic [26:0] pack_imm27(input int v);
        logic [DATA_W-1:0] t;
        t = to48(v);
        return t[26:0];
    endfunction

    function automatic logic [3:0] pack_subop(input int s);
        return 4'(s);
    endfunction

    function automatic logic [DATA_W-1:0] instr_ld(input logic p, input int r, input int b, input int disp);
        return {OP_LD, p, 3'(r), 3'(b), 4'b0, pack_disp33(disp)};
    endfunction

    function automatic logic [DATA_W-1:0] instr_st(input logic p, input int r, input int b, input int disp);
        return {OP_ST, p, 3'(r), 3'(b), 4'b0, pack_disp33(disp)};
    endfunction

    function automatic logic [DATA_W-1:0] instr_alui_a(input int sub, input int r, input int b, input int imm);
        return {OP_ALUI_A, 1'b0, 3'(r), 3'(b), pack_subop(sub), 6'b0, pack_imm27(imm)};
    endfunction

    function automatic logic [DATA_W-1:0] instr_alui_d(input int sub, input int r, input int b, input int imm);
        return {OP_ALUI_D, 1'b0, 3'(r), 3'(b), pack_subop(sub), 6'b0, pack_imm27(imm)};
    endfunction

    function automatic logic [DATA_W-1:0] instr_sys(input int code);
        return {OP_SYS, 40'b0, 4'(code)};
    endfunction

endpackage

// File: rtl/cpu_ad48_ram.sv
// Word-addressed 48-bit memory: combinational read, write on rising edge, no reset.
module cpu_ad48_ram
    import cpu_ad48_pkg::*;
#(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_ad48_regfile.sv
// 8 x 48-bit register file, two combinational read ports, one write port;
// ZERO_REG makes entry 0 read as zero and ignore writes.
module cpu_ad48_regfile
    import cpu_ad48_pkg::*;
#(
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [2:0]        ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [2:0]        ra2,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !(ZERO_REG && wa == 3'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ZERO_REG && ra1 == 3'd0) ? '0 : regs[ra1];
    assign rd2 = (ZERO_REG && ra2 == 3'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/cpu_ad48.sv
// Single-cycle 48-bit core: base+displacement load/store with optional base
// update, ALU-immediate on address or data registers, and a sticky HALT.
module cpu_ad48
    import cpu_ad48_pkg::*;
#(
    parameter int IM_WORDS = 128,
    parameter int DM_WORDS = 128
) (
    input  logic clk,
    input  logic resetn,
    output logic halt
);

    localparam int IM_AW = $clog2(IM_WORDS);
    localparam int DM_AW = $clog2(DM_WORDS);

    logic [IM_AW-1:0]  pc;
    logic [DATA_W-1:0] instr, a_b, a_r, d_b, d_r, dm_rdata;
    logic signed [DATA_W-1:0] disp, imm, ea;
    logic [3:0] opcode, subop, code;
    logic [2:0] r, b;
    logic       p;

    logic              a_we, d_we, dm_we, halt_set;
    logic [2:0]        a_wa, d_wa;
    logic [DATA_W-1:0] a_wd, d_wd;

    function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] f,
                                                 input logic [DATA_W-1:0] src,
                                                 input logic [DATA_W-1:0] imm_v);
        logic signed [DATA_W-1:0] src_s;
        logic [5:0] sh;
        logic       big;
        src_s = src;
        sh    = imm_v[5:0];
        big   = (sh >= 6'd48);
        case (f)
            F_ADD:   return src + imm_v;
            F_SUB:   return src - imm_v;
            F_AND:   return src & imm_v;
            F_OR:    return src | imm_v;
            F_XOR:   return src ^ imm_v;
            F_SHL:   return big ? '0 : src << sh;
            F_SHR:   return big ? '0 : src >> sh;
            F_SAR:   return big ? {DATA_W{src[DATA_W-1]}} : DATA_W'(src_s >>> sh);
            default: return imm_v;
        endcase
    endfunction

    assign opcode = instr[47:44];
    assign p      = instr[43];
    assign r      = instr[42:40];
    assign b      = instr[39:37];
    assign subop  = instr[36:33];
    assign code   = instr[3:0];
    assign disp   = {{(DATA_W-33){instr[32]}}, instr[32:0]};
    assign imm    = {{(DATA_W-27){instr[26]}}, instr[26:0]};
    assign ea     = $signed(a_b) + disp;

    always_comb begin
        a_we     = 1'b0;
        a_wa     = 3'd0;
        a_wd     = '0;
        d_we     = 1'b0;
        d_wa     = 3'd0;
        d_wd     = '0;
        dm_we    = 1'b0;
        halt_set = 1'b0;
        if (!halt) begin
            case (opcode)
                OP_SYS:    halt_set = (code == SYS_HALT);
                OP_ALUI_A: begin
                    a_we = 1'b1;
                    a_wa = r;
                    a_wd = alu_op(subop, a_b, imm);
                end
                OP_ALUI_D: begin
                    d_we = 1'b1;
                    d_wa = r;
                    d_wd = alu_op(subop, d_b, imm);
                end
                OP_LD: begin
                    d_we = 1'b1;
                    d_wa = r;
                    d_wd = dm_rdata;
                    a_we = p;
                    a_wa = b;
                    a_wd = ea;
                end
                OP_ST: begin
                    dm_we = 1'b1;
                    a_we  = p;
                    a_wa  = b;
                    a_wd  = ea;
                end
                default: ;
            endcase
        end
    end

    // PC wraps explicitly so non-power-of-two IMEM depths behave
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc   <= '0;
            halt <= 1'b0;
        end else if (!halt) begin
            pc <= (pc == IM_AW'(IM_WORDS - 1)) ? '0 : pc + 1'b1;
            if (halt_set) begin
                halt <= 1'b1;
            end
        end
    end

    cpu_ad48_ram #(.WORDS(IM_WORDS), .AW(IM_AW)) IMEM (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (pc),
        .rdata (instr)
    );

    cpu_ad48_ram #(.WORDS(DM_WORDS), .AW(DM_AW)) DMEM (
        .clk   (clk),
        .we    (dm_we),
        .waddr (ea[DM_AW-1:0]),
        .wdata (d_r),
        .raddr (ea[DM_AW-1:0]),
        .rdata (dm_rdata)
    );

    cpu_ad48_regfile #(.ZERO_REG(1'b1)) RF_A (
        .clk    (clk),
        .resetn (resetn),
        .we     (a_we),
        .wa     (a_wa),
        .wd     (a_wd),
        .ra1    (b),
        .rd1    (a_b),
        .ra2    (r),
        .rd2    (a_r)
    );

    cpu_ad48_regfile #(.ZERO_REG(1'b0)) RF_D (
        .clk    (clk),
        .resetn (resetn),
        .we     (d_we),
        .wa     (d_wa),
        .wd     (d_wd),
        .ra1    (b),
        .rd1    (d_b),
        .ra2    (r),
        .rd2    (d_r)
    );

    logic unused_ok;
    assign unused_ok = ^{ea[DATA_W-1:DM_AW], a_r};

endmodule

// File: tb/tb_cpu_ad48.sv
// Bench for cpu_ad48: assembles small programs into IMEM, preloads DMEM, and
// checks architectural state against a cycle-tagged expectation queue.
module tb_cpu_ad48;
    import cpu_ad48_pkg::*;

    localparam int KA = 0, KD = 1, KM = 2, KPC = 3, KH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [47:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] prog[$];

    cpu_ad48 #(.IM_WORDS(128), .DM_WORDS(128)) dut (
        .clk    (clk),
        .resetn (resetn),
        .halt   (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] peek(input int kind, input int idx);
        case (kind)
            KA:      return dut.RF_A.regs[idx];
            KD:      return dut.RF_D.regs[idx];
            KM:      return dut.DMEM.mem[idx];
            KPC:     return 48'(dut.pc);
            default: return 48'(halt);
        endcase
    endfunction

    task automatic push_exp(input int cyc, input int kind, input int idx, input logic [47:0] v, input string nm);
        sb.push_back('{cyc, kind, idx, v, nm});
    endtask

    // Hold reset, load prog into IMEM (rest NOP), DMEM[i]=100*(i+1) for i<9, then release
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        for (int i = 0; i < 128; i++) begin
            dut.IMEM.mem[i] <= (i < prog.size()) ? prog[i] : {4'hF, 44'b0};
            dut.DMEM.mem[i] <= (i < 9) ? to48(100 * (i + 1)) : '0;
        end
        #1;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [47:0] got;
        resetn = 1'b0;
        #2;
        checks++;
        if (dut.pc !== 7'd0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", dut.pc); end
        checks++;
        if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %0b expected 0", halt); end
        for (int i = 0; i < 8; i++) begin
            got = dut.RF_A.regs[i];
            checks++;
            if (got !== '0) begin errors++; $display("FAIL reset_A%0d: got %0h expected 0", i, got); end
            got = dut.RF_D.regs[i];
            checks++;
            if (got !== '0) begin errors++; $display("FAIL reset_D%0d: got %0h expected 0", i, got); end
        end
    endtask

    task automatic test_loads();
        exp_t e;
        logic [47:0] got;
        prog = '{instr_ld(1'b0, 0, 0, 0), instr_ld(1'b0, 1, 0, 1),
                 instr_alui_a(F_ADD, 1, 1, 2), instr_ld(1'b1, 3, 1, 2),
                 instr_ld(1'b0, 4, 1, -1)};
        push_exp(1, KD, 0, to48(100), "ld_D0");
        push_exp(2, KD, 1, to48(200), "ld_D1");
        push_exp(3, KA, 1, to48(2),   "addi_A1");
        push_exp(4, KD, 3, to48(500), "ldp_D3");
        push_exp(4, KA, 1, to48(4),   "ldp_A1");
        push_exp(5, KD, 4, to48(400), "ld_neg_D4");
        push_exp(5, KA, 1, to48(4),   "ld_nop_A1");
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                got = peek(e.kind, e.idx);
                checks++;
                if (got !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
            end
        end
    endtask

    task automatic test_store_a0();
        exp_t e;
        logic [47:0] got;
        prog = '{instr_alui_a(F_MOV, 1, 0, 4), instr_alui_d(F_MOV, 5, 0, 12345),
                 instr_st(1'b0, 5, 1, 0), instr_ld(1'b0, 6, 1, 0),
                 instr_st(1'b1, 5, 1, -2), instr_ld(1'b1, 1, 0, 2),
                 instr_alui_a(F_MOV, 0, 0, 77)};
        push_exp(1, KA, 1, to48(4),     "mov_A1");
        push_exp(2, KD, 5, to48(12345), "mov_D5");
        push_exp(3, KM, 4, to48(12345), "st_mem4");
        push_exp(4, KD, 6, to48(12345), "ld_back_D6");
        push_exp(5, KM, 2, to48(12345), "stp_mem2");
        push_exp(5, KA, 1, to48(2),     "stp_A1");
        push_exp(6, KD, 1, to48(12345), "ldp_a0_D1");
        push_exp(6, KA, 0, to48(0),     "ldp_a0_A0");
        push_exp(7, KA, 0, to48(0),     "alui_a0_A0");
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                got = peek(e.kind, e.idx);
                checks++;
                if (got !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
            end
        end
    endtask

    task automatic test_mixed();
        exp_t e;
        logic [47:0] got;
        prog = '{instr_alui_a(F_MOV, 2, 0, 5), instr_alui_d(F_MOV, 6, 0, 67890),
                 instr_st(1'b1, 6, 2, 3), instr_ld(1'b1, 7, 2, -2),
                 instr_ld(1'b1, 4, 2, -1), instr_ld(1'b0, 0, 2, 3),
                 instr_ld(1'b0, 1, 0, 129), instr_ld(1'b0, 2, 0, -127)};
        push_exp(3, KM, 8, to48(67890), "mix_st_mem8");
        push_exp(3, KA, 2, to48(8),     "mix_st_A2");
        push_exp(4, KD, 7, to48(700),   "mix_ld_D7");
        push_exp(4, KA, 2, to48(6),     "mix_ld_A2a");
        push_exp(5, KD, 4, to48(600),   "mix_ld_D4");
        push_exp(5, KA, 2, to48(5),     "mix_ld_A2b");
        push_exp(6, KD, 0, to48(67890), "mix_ld_D0");
        push_exp(7, KD, 1, to48(200),   "ea_wrap_pos");
        push_exp(8, KD, 2, to48(200),   "ea_wrap_neg");
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                got = peek(e.kind, e.idx);
                checks++;
                if (got !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
            end
        end
    endtask

    task automatic test_alu();
        exp_t e;
        logic [47:0] got;
        prog = '{instr_alui_d(F_MOV, 1, 0, -1),     instr_alui_d(F_MOV, 2, 0, 61680),
                 instr_alui_d(F_ADD, 3, 2, 5),      instr_alui_d(F_SUB, 3, 3, 61690),
                 instr_alui_d(F_AND, 4, 1, 255),    instr_alui_d(F_OR, 4, 4, 768),
                 instr_alui_d(F_XOR, 4, 4, 240),    instr_alui_d(F_SHL, 5, 2, 4),
                 instr_alui_d(F_SHR, 5, 1, 40),     instr_alui_d(F_SAR, 6, 3, 1),
                 instr_alui_d(F_SAR, 7, 3, 50),     instr_alui_d(F_SHL, 7, 2, 48),
                 instr_alui_d(F_SHR, 0, 1, 47),     instr_alui_a(F_ADD, 3, 0, -3),
                 instr_alui_d(12, 0, 0, 9)};
        push_exp(1,  KD, 1, 48'hFFFF_FFFF_FFFF, "mov_neg");
        push_exp(2,  KD, 2, to48(61680),        "mov_pos");
        push_exp(3,  KD, 3, to48(61685),        "add");
        push_exp(4,  KD, 3, 48'hFFFF_FFFF_FFFB, "sub_wrap");
        push_exp(5,  KD, 4, to48(255),          "and");
        push_exp(6,  KD, 4, to48(1023),         "or");
        push_exp(7,  KD, 4, to48(783),          "xor");
        push_exp(8,  KD, 5, to48(986880),       "shl");
        push_exp(9,  KD, 5, to48(255),          "shr");
        push_exp(10, KD, 6, 48'hFFFF_FFFF_FFFD, "sar");
        push_exp(11, KD, 7, 48'hFFFF_FFFF_FFFF, "sar_big");
        push_exp(12, KD, 7, to48(0),            "shl_big");
        push_exp(13, KD, 0, to48(1),            "shr_47");
        push_exp(14, KA, 3, 48'hFFFF_FFFF_FFFD, "alui_a_wrap");
        push_exp(15, KD, 0, to48(9),            "mov_sub12");
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                got = peek(e.kind, e.idx);
                checks++;
                if (got !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
            end
        end
    endtask

    task automatic test_halt_reset();
        exp_t e;
        logic [47:0] got;
        prog = '{instr_alui_d(F_MOV, 1, 0, 11), instr_sys(3),
                 instr_alui_d(F_MOV, 2, 0, 22), instr_sys(15),
                 instr_alui_d(F_MOV, 3, 0, 33), instr_st(1'b1, 1, 1, 0)};
        push_exp(1, KD, 1, to48(11), "h_mov_D1");
        push_exp(2, KH, 0, to48(0),  "sys_nop_halt");
        push_exp(3, KD, 2, to48(22), "h_mov_D2");
        push_exp(4, KH, 0, to48(1),  "halt_set");
        push_exp(4, KPC, 0, to48(4), "halt_pc");
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            while (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                got = peek(e.kind, e.idx);
                checks++;
                if (got !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
            end
        end
        repeat (20) begin @(posedge clk); #1; end
        checks++;
        if (dut.pc !== 7'd4) begin errors++; $display("FAIL frozen_pc: got %0h expected 4", dut.pc); end
        checks++;
        if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %0b expected 1", halt); end
        got = dut.RF_D.regs[3];
        checks++;
        if (got !== '0) begin errors++; $display("FAIL frozen_D3: got %0h expected 0", got); end
        got = dut.RF_D.regs[2];
        checks++;
        if (got !== to48(22)) begin errors++; $display("FAIL frozen_D2: got %0h expected 16", got); end

        // Asynchronous reset asserted mid-cycle while halted
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (dut.pc !== 7'd0) begin errors++; $display("FAIL midrst_pc: got %0h expected 0", dut.pc); end
        checks++;
        if (halt !== 1'b0) begin errors++; $display("FAIL midrst_halt: got %0b expected 0", halt); end
        got = dut.RF_D.regs[1];
        checks++;
        if (got !== '0) begin errors++; $display("FAIL midrst_D1: got %0h expected 0", got); end
        got = dut.DMEM.mem[0];
        checks++;
        if (got !== to48(100)) begin errors++; $display("FAIL midrst_dmem0: got %0h expected 64", got); end
        got = dut.IMEM.mem[3];
        checks++;
        if (got !== instr_sys(15)) begin errors++; $display("FAIL midrst_imem3: got %0h expected %0h", got, instr_sys(15)); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        got = dut.RF_D.regs[1];
        checks++;
        if (got !== to48(11)) begin errors++; $display("FAIL restart_D1: got %0h expected b", got); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_a0();
        test_mixed();
        test_alu();
        test_halt_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
